// File: rtl/ram_bus_pkg.sv
// Shared types and defaults for the scratch-RAM bus initiator.
// Optional write verify is enabled with RAM_BUS_WRITE_VERIFY_EN.
package ram_bus_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    HOLD    = 3'd3,
    TURN    = 3'd4,
    VACCESS = 3'd5,
    RESP    = 3'd6
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic logic [CNT_W-1:0] strobe_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/ram_bus_strobe_cnt.sv
// Loadable down-counter timing the chip-select strobe.
// Shared by the write/read access and the verify read-back.
module ram_bus_strobe_cnt
  import ram_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ram_bus_master.sv
// Single-word initiator for the asynchronous scratch RAM.
// Build with RAM_BUS_WRITE_VERIFY_EN to read back every write.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_cs,
  output logic              ram_we,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam logic [CNT_W-1:0] LOAD_V = strobe_load(STROBE_CYCLES);

  state_t            state;
  logic              op_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drv;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;

`ifdef RAM_BUS_WRITE_VERIFY_EN
  logic err_q;
  assign cnt_load = (state == SETUP) || (state == TURN);
  assign cnt_en   = (state == ACCESS) || (state == VACCESS);
  assign rsp_err  = err_q;
`else
  assign cnt_load = (state == SETUP);
  assign cnt_en   = (state == ACCESS);
  assign rsp_err  = 1'b0;
`endif

  ram_bus_strobe_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LOAD_V),
    .zero     (cnt_zero)
  );

  // Only this block ever drives the RAM bus, and only for writes.
  assign ram_data  = drv ? wdata_q : {DATA_W{1'bz}};
  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= OP_READ;
      wdata_q     <= '0;
      drv         <= 1'b0;
      ram_address <= '0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
`ifdef RAM_BUS_WRITE_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q        <= req_we;
            wdata_q     <= req_wdata;
            ram_address <= req_addr;
            ram_we      <= req_we;
            drv         <= req_we;
            state       <= SETUP;
          end
        end
        SETUP: begin
          ram_cs <= 1'b1;
          state  <= ACCESS;
        end
        ACCESS: begin
          if (cnt_zero) begin
            ram_cs <= 1'b0;
            state  <= HOLD;
            if (op_q == OP_READ) begin
              rsp_rdata <= ram_data;
            end
          end
        end
        HOLD: begin
          ram_we <= 1'b0;
          drv    <= 1'b0;
`ifdef RAM_BUS_WRITE_VERIFY_EN
          if (op_q == OP_WRITE) begin
            state <= TURN;
          end else begin
            err_q     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`else
          if (op_q == OP_WRITE) begin
            rsp_rdata <= wdata_q;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
`endif
        end
`ifdef RAM_BUS_WRITE_VERIFY_EN
        TURN: begin
          ram_cs <= 1'b1;
          state  <= VACCESS;
        end
        VACCESS: begin
          if (cnt_zero) begin
            ram_cs    <= 1'b0;
            rsp_rdata <= ram_data;
            err_q     <= (ram_data != wdata_q);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
`endif
        RESP: begin
          state <= IDLE;
        end
        default: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          drv    <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Randomised scoreboard bench for ram_bus_master (strobe 2 and 1).
// Define RAM_BUS_WRITE_VERIFY_EN to exercise the read-back path.
module tb_ram_bus_master;

`ifdef RAM_BUS_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  typedef struct {
    logic [3:0] d;
    logic       e;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  logic [1:0]       rv;
  logic [1:0]       rwe;
  logic [1:0][11:0] ra;
  logic [1:0][3:0]  rwd;
  wire  [1:0]       rdy, vld, rerr, bsy, cs, we;
  wire  [1:0][3:0]  rdat;
  wire  [1:0][11:0] ao;
  wire  [3:0]       bus0, bus1;

  logic [3:0] mem     [2][4096];
  logic [3:0] ref_mem [2][4096];
  logic [3:0] stuck   [2];
  logic [3:0] cur_wd  [2];
  int         last_acc[2];
  int         cs_run  [2];
  int         we_run  [2];
  bit         chk_gap;
  exp_t       q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_bus_master #(.STROBE_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]),
    .rsp_valid(vld[0]), .rsp_rdata(rdat[0]), .rsp_err(rerr[0]),
    .busy(bsy[0]), .ram_address(ao[0]), .ram_cs(cs[0]),
    .ram_we(we[0]), .ram_data(bus0)
  );

  ram_bus_master #(.STROBE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]),
    .rsp_valid(vld[1]), .rsp_rdata(rdat[1]), .rsp_err(rerr[1]),
    .busy(bsy[1]), .ram_address(ao[1]), .ram_cs(cs[1]),
    .ram_we(we[1]), .ram_data(bus1)
  );

  // Asynchronous RAM models with optional stuck-at-0 bits
  assign bus0 = (cs[0] && !we[0]) ? mem[0][ao[0]] : 4'bz;
  assign bus1 = (cs[1] && !we[1]) ? mem[1][ao[1]] : 4'bz;

  always @(posedge clk) begin
    if (cs[0] && we[0]) mem[0][ao[0]] <= bus0 & ~stuck[0];
    if (cs[1] && we[1]) mem[1][ao[1]] <= bus1 & ~stuck[1];
  end

  function automatic int sc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic issue(input int i, input bit w, input logic [11:0] a,
                       input logic [3:0] d, input bit keep,
                       input bit track);
    exp_t e;
    int n;
    logic [3:0] st;
    rv[i] = 1'b1; rwe[i] = w; ra[i] = a; rwd[i] = d;
    n = 0;
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) begin
      checks++; fails++;
      $display("FAIL accept_timeout inst=%0d got=0 want=1", i);
      rv[i] = 1'b0;
      return;
    end
    if (chk_gap) chk("accept_gap", cyc - last_acc[i], sc(i) + 4);
    last_acc[i] = cyc;
    if (track) begin
      if (w) begin
        st = d & ~stuck[i];
        ref_mem[i][a] = st;
        e.d = VER ? st : d;
        e.e = VER && (st != d);
        e.due = cyc + (VER ? 2 * sc(i) + 4 : sc(i) + 3);
      end else begin
        e.d = ref_mem[i][a];
        e.e = 1'b0;
        e.due = cyc + sc(i) + 3;
      end
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    cur_wd[i] = d;
    @(negedge clk);
    if (!keep) rv[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q0.size() + q1.size(), 0);
  endtask

  // Scoreboard monitor plus per-cycle bus discipline
  always @(negedge clk) begin
    exp_t x;
    logic [3:0] bv;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        cs_run[i] = 0;
        we_run[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bv = (i == 0) ? bus0 : bus1;
        if (vld[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_rsp inst=%0d got=1 want=0", i);
          end else begin
            x = (i == 0) ? q0.pop_front() : q1.pop_front();
            checks++;
            if (rdat[i] !== x.d || rerr[i] !== x.e || cyc != x.due) begin
              fails++;
              $display("FAIL rsp inst=%0d got d=%h e=%b cyc=%0d want d=%h e=%b cyc=%0d",
                       i, rdat[i], rerr[i], cyc, x.d, x.e, x.due);
            end
          end
        end
        if (cs[i] && !we[i]) chk("bus_read_val", bv, mem[i][ao[i]]);
        if (we[i]) chk("bus_write_val", bv, cur_wd[i]);
        if (cs[i]) cs_run[i]++;
        else if (cs_run[i] > 0) begin
          chk("cs_width", cs_run[i], sc(i));
          cs_run[i] = 0;
        end
        if (we[i]) we_run[i]++;
        else if (we_run[i] > 0) begin
          chk("we_width", we_run[i], sc(i) + 2);
          we_run[i] = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] v;
    bit w;
    reset = 1'b1;
    rv = '0; rwe = '0; ra = '0; rwd = '0;
    chk_gap = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stuck[i] = 4'h0; cur_wd[i] = 4'h0;
      last_acc[i] = 0; cs_run[i] = 0; we_run[i] = 0;
      for (int a = 0; a < 4096; a++) begin
        v = 4'($urandom);
        mem[i][a] = v;
        ref_mem[i][a] = v;
      end
    end
    mem[1][12'h010] = 4'h5;
    ref_mem[1][12'h010] = 4'h5;

    repeat (2) @(negedge clk);
    chk("rst_cs", cs[0], 1'b0);
    chk("rst_we", we[0], 1'b0);
    chk("rst_addr", ao[0], 12'h000);
    chk("rst_valid", vld[0], 1'b0);
    chk("rst_rdata", rdat[0], 4'h0);
    chk("rst_err", rerr[0], 1'b0);
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_ready", rdy, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy, 2'b11);

    issue(0, 1'b1, 12'h123, 4'hA, 1'b0, 1'b1);
    issue(0, 1'b0, 12'h123, 4'h0, 1'b0, 1'b1);
    drain();

    chk_gap = 1'b0;
    issue(0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b1);
    chk_gap = 1'b1;
    issue(0, 1'b0, 12'hFFF, 4'h0, 1'b1, 1'b1);
    issue(0, 1'b0, 12'h7FF, 4'h0, 1'b0, 1'b1);
    chk_gap = 1'b0;
    drain();

    issue(1, 1'b0, 12'h010, 4'h0, 1'b0, 1'b1);
    issue(1, 1'b1, 12'h011, 4'hC, 1'b0, 1'b1);
    issue(1, 1'b0, 12'h011, 4'h0, 1'b0, 1'b1);
    drain();

    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom);
      issue(0, w, 12'h300 + 12'($urandom_range(0, 15)), 4'($urandom),
            1'($urandom), 1'b1);
    end
    rv[0] = 1'b0;
    drain();

`ifdef RAM_BUS_WRITE_VERIFY_EN
    issue(0, 1'b1, 12'h020, 4'h3, 1'b0, 1'b1);
    drain();
    stuck[0] = 4'h1;
    issue(0, 1'b1, 12'h020, 4'h3, 1'b0, 1'b1);
    drain();
    stuck[0] = 4'h0;
`endif

    issue(0, 1'b1, 12'h200, 4'h9, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_cs", cs[0], 1'b1);
    chk("pre_rst_busy", bsy[0], 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", cs[0], 1'b0);
    chk("mid_rst_we", we[0], 1'b0);
    chk("mid_rst_busy", bsy[0], 1'b0);
    chk("mid_rst_ready", rdy[0], 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", rdy[0], 1'b1);
    repeat (10) @(negedge clk);
    chk("post_rst_idle", bsy[0], 1'b0);

    issue(0, 1'b0, 12'h123, 4'h0, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Bus initiator for the processor's 4-bit asynchronous scratch RAM, whose port is address, cs, we and a bidirectional data bus. It takes single-word read/write requests from the core over a valid/ready handshake and sequences the RAM pins with explicit setup, strobe and hold phases. It owns the tri-state data driver so the bus never has contention, and returns one response pulse per request. It sits between the core's datapath/control decode and the RAM instance.

## Interface
- ADDR_W, 12, RAM address width
- DATA_W, 4, RAM word width
- STROBE_CYCLES, 2, cycles ram_cs is held high per access (legal range 1..15)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; for writes, see Operation
- rsp_err  out  1  write-verify mismatch flag, valid with rsp_valid
- busy  out  1  high in every state except IDLE
- ram_address  out  ADDR_W  RAM address pins
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_data  inout  DATA_W  RAM data bus

## Operation
- Accept: a request is taken on a clk edge where req_valid && req_ready. At that edge the block latches req_we, req_addr and req_wdata. req_ready = (state == IDLE). There is no queue.
- States: IDLE, SETUP, ACCESS, HOLD, TURN, VACCESS, RESP. TURN and VACCESS exist only with the verify feature.
- IDLE: ram_cs=0, ram_we=0, bus released. Goes to SETUP on accept.
- SETUP (1 cycle):
  - ram_address = latched address; ram_cs=0; ram_we = latched we.
  - On a write, the block drives the bus with wdata.
- ACCESS (STROBE_CYCLES cycles):
  - ram_cs=1; ram_we and the bus are held as in SETUP. Reads leave the bus released.
  - The strobe counter loads STROBE_CYCLES-1 on entry and decrements each cycle.
  - On a read, ram_data is captured into rsp_rdata on the edge that leaves ACCESS (counter == 0).
- HOLD (1 cycle): ram_cs=0. On a write, ram_we stays 1 and data stays driven; on a read, ram_we=0.
  - HOLD → RESP, or → TURN for a verified write.
- RESP (1 cycle): rsp_valid=1, then IDLE.
- Outside RESP, rsp_rdata and rsp_err hold their last values.
- Bus drive enable = (op == write) && state ∈ {SETUP, ACCESS, HOLD}. The block never drives in any other state.
- ram_address holds the latched address from SETUP until IDLE.
- For writes without verify, rsp_rdata = written data and rsp_err = 0.

## Timing
- Reset (async, immediate):
  - Outputs: ram_cs=0, ram_we=0, bus released, ram_address=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; state IDLE.
  - req_ready is 0 while reset is asserted and 1 from the first cycle after release.
- Latency from the accept edge, counting the SETUP cycle as cycle 1:
  - Read or plain write: rsp_valid in cycle STROBE_CYCLES+3 (5 at the default).
  - Verified write: rsp_valid in cycle 2·STROBE_CYCLES+4 (8 at the default).
- Throughput: the next accept is possible in the cycle after RESP, giving one request per STROBE_CYCLES+4 cycles.
- Reset mid-operation: the request is abandoned. No rsp_valid is produced, and the RAM contents at that address are unspecified.
- req_valid is ignored while busy. The core must hold req_valid and the request fields until it is accepted.
- STROBE_CYCLES=1: ACCESS lasts one cycle and read capture happens at the end of that cycle.

## Configuration
- Macro RAM_BUS_WRITE_VERIFY_EN.
- Defined: every write is followed by a read-back.
  - HOLD → TURN (1 cycle): ram_we=0, ram_cs=0, bus released.
  - TURN → VACCESS (STROBE_CYCLES cycles): ram_cs=1, ram_we=0. ram_data is captured into rsp_rdata on exit.
  - VACCESS → RESP, with rsp_err = (read-back != written data).
- Undefined: the TURN and VACCESS states and their logic are not compiled, rsp_err is tied to 0, and writes take the plain-write latency.

## Structure
- Package ram_bus_pkg holds:
  - the state encoding constants (IDLE..RESP);
  - the OP_READ and OP_WRITE constants;
  - default ADDR_W and DATA_W.
- Sub-module ram_bus_strobe_cnt: a 4-bit loadable down-counter with load, enable and asynchronous reset, producing a zero flag. It is reused for ACCESS and VACCESS.
- Tri-state drive is a single continuous assignment in the top module.

## Test plan
- Write then read (STROBE_CYCLES=2): write 0xA to 0x123, then read 0x123.
  - Write: ram_cs high for exactly 2 cycles; ram_we rises in SETUP and falls after HOLD; rsp_valid in cycle 5.
  - Read: rsp_rdata=0xA in cycle 5.
- Bus discipline: monitor every cycle. The block drives ram_data only when ram_we=1 or in a write's SETUP or HOLD; on reads, ram_data is never driven while cs=1 and we=0.
- Handshake: hold req_valid high with three back-to-back reads (0x000, 0xFFF, 0x7FF).
  - Each is accepted only when req_ready=1, spaced 6 cycles apart.
  - Responses arrive in order.
- Reset in ACCESS: assert reset during a write's ACCESS cycle.
  - Same cycle: ram_cs and ram_we go low and the bus is released.
  - No rsp_valid is produced; req_ready=1 after reset is released.
- STROBE_CYCLES=1: a read of a preloaded 0x5 at 0x010 returns 0x5 in cycle 4.
- With RAM_BUS_WRITE_VERIFY_EN, write 0x3 to 0x020:
  - Clean RAM: rsp_valid in cycle 8 with rsp_err=0 and rsp_rdata=0x3.
  - With the bench forcing bit0 of the RAM stuck at 0: rsp_err=1 and rsp_rdata=0x2.
